// File: rtl/reg_bus_ctrl.sv
// Register-transfer sequencer: MOV latency 1, ALU latency 2; cmd_ready low while busy.
// Define REG_BUS_CTRL_PIPE_EN to accept back-to-back commands in MOV/ALU_WB/NOP/ERR.
module reg_bus_ctrl #(
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_src_a,
  input  logic [2:0]       cmd_src_b,
  input  logic [2:0]       cmd_dst,
  output logic [NREGS-1:0] rdata,
  output logic [NREGS-1:0] wdata,
  output logic [NREGS-1:0] raddr,
  output logic [NREGS-1:0] waddr,
  output logic [NREGS-1:0] alu_r_a,
  output logic [NREGS-1:0] alu_r_b,
  output logic [NREGS-1:0] alu_w,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE, S_MOV, S_ALU_RD, S_ALU_WB, S_NOP, S_ERR
  } state_t;

  localparam logic [1:0] OP_MOVD = 2'b00;
  localparam logic [1:0] OP_MOVA = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [3:0] NR      = 4'(NREGS);

  state_t     state, next_state, cmd_state;
  logic [1:0] op_q;
  logic [2:0] src_a_q, src_b_q, dst_q;
  logic       err_q;
  logic       accept;
  logic       bad_a, bad_b, bad_d;

  function automatic logic [NREGS-1:0] dec(input logic [2:0] idx);
    dec = '0;
    for (int i = 0; i < NREGS; i++)
      if (idx == 3'(i)) dec[i] = 1'b1;
  endfunction

  assign accept = cmd_valid && cmd_ready;
  assign bad_a  = {1'b0, cmd_src_a} >= NR;
  assign bad_b  = {1'b0, cmd_src_b} >= NR;
  assign bad_d  = {1'b0, cmd_dst}   >= NR;

  // First state of the command being offered; out-of-range indices divert to ERR.
  always_comb begin
    cmd_state = S_NOP;
    case (cmd_op)
      OP_MOVD, OP_MOVA: cmd_state = (bad_a || bad_d) ? S_ERR : S_MOV;
      OP_ALU:           cmd_state = (bad_a || bad_b || bad_d) ? S_ERR : S_ALU_RD;
      default:          cmd_state = S_NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        op_q    <= cmd_op;
        src_a_q <= cmd_src_a;
        src_b_q <= cmd_src_b;
        dst_q   <= cmd_dst;
      end
      if (next_state == S_ERR) err_q <= 1'b1;
    end
  end

  // Accept is only possible in states where cmd_ready may be high.
  always_comb begin
    next_state = S_IDLE;
    if (state == S_ALU_RD)
      next_state = S_ALU_WB;
    else if (accept)
      next_state = cmd_state;
  end

  always_comb begin
    rdata   = '0;
    wdata   = '0;
    raddr   = '0;
    waddr   = '0;
    alu_r_a = '0;
    alu_r_b = '0;
    alu_w   = '0;
    done    = 1'b0;
    cmd_ready = 1'b0;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_MOV: begin
        if (op_q == OP_MOVD) begin
          rdata = dec(src_a_q);
          wdata = dec(dst_q);
        end else begin
          raddr = dec(src_a_q);
          waddr = dec(dst_q);
        end
        done = 1'b1;
`ifdef REG_BUS_CTRL_PIPE_EN
        cmd_ready = 1'b1;
`endif
      end
      S_ALU_RD: begin
        alu_r_a = dec(src_a_q);
        alu_r_b = dec(src_b_q);
      end
      S_ALU_WB: begin
        alu_r_a = dec(src_a_q);
        alu_r_b = dec(src_b_q);
        alu_w   = dec(dst_q);
        done    = 1'b1;
`ifdef REG_BUS_CTRL_PIPE_EN
        cmd_ready = 1'b1;
`endif
      end
      S_NOP: begin
        done = 1'b1;
`ifdef REG_BUS_CTRL_PIPE_EN
        cmd_ready = 1'b1;
`endif
      end
      S_ERR: begin
`ifdef REG_BUS_CTRL_PIPE_EN
        cmd_ready = 1'b1;
`endif
      end
      default: cmd_ready = 1'b0;
    endcase
    if (rst) cmd_ready = 1'b0;
  end

  assign err = err_q;

endmodule
